// File: rtl/conv1d_stream_mac_if.sv
// Weight-load and result stream bundle for conv1d_stream_mac.
// The master side is the environment (fetch logic / consumer); the slave side is the engine.
interface conv1d_stream_mac_if #(
  parameter int ACTIV_BITS = 16,
  parameter int POS_W      = 1,
  parameter int FIL_W      = 1
);
  logic                         w_valid;
  logic                         w_ready;
  logic signed [ACTIV_BITS-1:0] w_data;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [ACTIV_BITS-1:0] out_data;
  logic [POS_W-1:0]             out_pos;
  logic [FIL_W-1:0]             out_filter;
  logic                         out_last;

  modport master (
    output w_valid, w_data, out_ready,
    input  w_ready, out_valid, out_data, out_pos, out_filter, out_last
  );

  modport slave (
    input  w_valid, w_data, out_ready,
    output w_ready, out_valid, out_data, out_pos, out_filter, out_last
  );
endinterface

// File: rtl/conv1d_stream_mac.sv
// Time-multiplexed 1-D convolution: streamed weight load, one signed MAC per cycle,
// rescale/ReLU/saturate, and a backpressured position-major result stream.
module conv1d_stream_mac #(
  parameter int IN_LEN      = 40,
  parameter int IN_CH       = 1,
  parameter int NUM_FILTERS = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int STRIDE      = 1,
  parameter int PADDING     = 1,
  parameter int ACTIV_BITS  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int ACC_BITS    = 40
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               load_start,
  input  logic                               start,
  input  logic                               relu_en,
  input  logic [IN_LEN*IN_CH*ACTIV_BITS-1:0] data_in,
  conv1d_stream_mac_if.slave                 bus,
  output logic                               busy,
  output logic                               weights_loaded,
  output logic                               done
);
  localparam int OUT_LEN = (IN_LEN + 2*PADDING - KERNEL_SIZE)/STRIDE + 1;
  localparam int TAPS    = IN_CH*KERNEL_SIZE;
  localparam int NW      = NUM_FILTERS*(1+TAPS);
  localparam int NX      = IN_LEN*IN_CH;
  localparam int POS_W   = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
  localparam int FIL_W   = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam int K_W     = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int CH_W    = (IN_CH > 1) ? $clog2(IN_CH+1) : 1;
  localparam int TAP_W   = $clog2(TAPS+1);
  localparam int WIDX_W  = (NW > 1) ? $clog2(NW) : 1;
  localparam int XI_W    = (NX > 1) ? $clog2(NX) : 1;

  localparam logic [TAP_W-1:0]  TAP_LAST = TAP_W'(TAPS);
  localparam logic [K_W-1:0]    K_LAST   = K_W'(KERNEL_SIZE-1);
  localparam logic [POS_W-1:0]  POS_LAST = POS_W'(OUT_LEN-1);
  localparam logic [FIL_W-1:0]  FIL_LAST = FIL_W'(NUM_FILTERS-1);
  localparam logic [WIDX_W-1:0] W_LAST   = WIDX_W'(NW-1);
  localparam logic signed [ACC_BITS-1:0] SAT_MAX = {{(ACC_BITS-ACTIV_BITS+1){1'b0}}, {(ACTIV_BITS-1){1'b1}}};
  localparam logic signed [ACC_BITS-1:0] SAT_MIN = {{(ACC_BITS-ACTIV_BITS+1){1'b1}}, {(ACTIV_BITS-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_EMIT, S_DONE} state_t;

  function automatic logic signed [ACTIV_BITS-1:0] rescale(input logic signed [ACC_BITS-1:0] acc,
                                                           input logic relu);
    logic signed [ACC_BITS-1:0] r;
    r = acc >>> FRAC_BITS;
    if (relu && r < 0) r = '0;
    if (r > SAT_MAX) r = SAT_MAX;
    else if (r < SAT_MIN) r = SAT_MIN;
    return r[ACTIV_BITS-1:0];
  endfunction

  state_t                  state_q;
  logic                    wl_q, done_q, relu_q;
  logic [WIDX_W-1:0]       widx_q;
  logic [POS_W-1:0]        pos_q;
  logic [FIL_W-1:0]        f_q;
  logic [TAP_W-1:0]        tap_q;
  logic [K_W-1:0]          k_q;
  logic [CH_W-1:0]         ch_q;
  logic                    ov_q, olast_q;
  logic signed [ACTIV_BITS-1:0] odata_q;
  logic [POS_W-1:0]        opos_q;
  logic [FIL_W-1:0]        ofil_q;

  // Datapath storage: weights, latched frame and accumulator carry no reset.
  logic signed [ACTIV_BITS-1:0]   wmem [NW];
  logic signed [ACTIV_BITS-1:0]   xmem [NX];
  logic signed [ACC_BITS-1:0]     acc_q;

  logic                           start_acc, w_hs, mac_step, res_step, emit_acc, is_last;
  logic [FIL_W-1:0]               next_f;
  logic [POS_W-1:0]               next_pos;
  logic signed [31:0]             idx;
  logic signed [ACTIV_BITS-1:0]   x_cur, w_cur, bias_first, bias_next;
  logic signed [2*ACTIV_BITS-1:0] prod;

  always_comb begin
    start_acc = (state_q == S_IDLE) && !load_start && start && wl_q;
    w_hs      = (state_q == S_LOAD) && bus.w_valid;
    mac_step  = (state_q == S_MAC) && (tap_q != TAP_LAST);
    res_step  = (state_q == S_MAC) && (tap_q == TAP_LAST);
    emit_acc  = (state_q == S_EMIT) && bus.out_ready && !olast_q;
    is_last   = (pos_q == POS_LAST) && (f_q == FIL_LAST);
    next_f    = (f_q == FIL_LAST) ? '0 : f_q + 1'b1;
    next_pos  = (f_q == FIL_LAST) ? pos_q + 1'b1 : pos_q;
    // Input index for the current tap; anything outside the frame is padding.
    idx       = $signed(32'(pos_q)) * STRIDE + $signed(32'(k_q)) - PADDING;
    x_cur     = '0;
    if (idx >= 0 && idx < IN_LEN)
      x_cur = xmem[XI_W'(idx * IN_CH + $signed(32'(ch_q)))];
    w_cur      = wmem[WIDX_W'(32'(f_q) * (1+TAPS) + 1 + 32'(tap_q))];
    bias_first = wmem[0];
    bias_next  = wmem[WIDX_W'(32'(next_f) * (1+TAPS))];
    prod       = w_cur * x_cur;
  end

  always_ff @(posedge clk) begin
    if (w_hs) wmem[widx_q] <= bus.w_data;
    if (start_acc) begin
      for (int i = 0; i < NX; i++) xmem[i] <= data_in[i*ACTIV_BITS +: ACTIV_BITS];
      acc_q <= ACC_BITS'(bias_first) <<< FRAC_BITS;
    end else if (mac_step) begin
      acc_q <= acc_q + ACC_BITS'(prod);
    end else if (emit_acc) begin
      acc_q <= ACC_BITS'(bias_next) <<< FRAC_BITS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wl_q    <= 1'b0;
      done_q  <= 1'b0;
      relu_q  <= 1'b0;
      widx_q  <= '0;
      pos_q   <= '0;
      f_q     <= '0;
      tap_q   <= '0;
      k_q     <= '0;
      ch_q    <= '0;
      ov_q    <= 1'b0;
      olast_q <= 1'b0;
      odata_q <= '0;
      opos_q  <= '0;
      ofil_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_start) begin
            state_q <= S_LOAD;
            wl_q    <= 1'b0;
            widx_q  <= '0;
          end else if (start_acc) begin
            state_q <= S_MAC;
            relu_q  <= relu_en;
            pos_q   <= '0;
            f_q     <= '0;
            tap_q   <= '0;
            k_q     <= '0;
            ch_q    <= '0;
          end
        end
        S_LOAD: begin
          if (w_hs) begin
            widx_q <= widx_q + 1'b1;
            if (widx_q == W_LAST) begin
              wl_q    <= 1'b1;
              state_q <= S_IDLE;
            end
          end
        end
        S_MAC: begin
          if (res_step) begin
            odata_q <= rescale(acc_q, relu_q);
            opos_q  <= pos_q;
            ofil_q  <= f_q;
            olast_q <= is_last;
            ov_q    <= 1'b1;
            state_q <= S_EMIT;
          end else begin
            tap_q <= tap_q + 1'b1;
            if (k_q == K_LAST) begin
              k_q  <= '0;
              ch_q <= ch_q + 1'b1;
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
        end
        S_EMIT: begin
          if (bus.out_ready) begin
            ov_q <= 1'b0;
            if (olast_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              f_q     <= next_f;
              pos_q   <= next_pos;
              tap_q   <= '0;
              k_q     <= '0;
              ch_q    <= '0;
              state_q <= S_MAC;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.w_ready    = (state_q == S_LOAD);
  assign bus.out_valid  = ov_q;
  assign bus.out_data   = odata_q;
  assign bus.out_pos    = opos_q;
  assign bus.out_filter = ofil_q;
  assign bus.out_last   = olast_q;
  assign busy           = (state_q != S_IDLE);
  assign weights_loaded = wl_q;
  assign done           = done_q;
endmodule

// File: tb/tb_conv1d_stream_mac.sv
// Directed bench for conv1d_stream_mac: a stride-1 and a stride-2 instance share stimulus;
// expected results come from hand-computed tables.
module tb_conv1d_stream_mac;
  logic        clk = 1'b0;
  logic        rst_n, load_start, start, relu_en;
  logic [63:0] data_in;
  logic        busy_b, wl_b, done_b, busy_s, wl_s, done_s;

  conv1d_stream_mac_if #(.ACTIV_BITS(16), .POS_W(2), .FIL_W(1)) ifb ();
  conv1d_stream_mac_if #(.ACTIV_BITS(16), .POS_W(1), .FIL_W(1)) ifs ();

  assign ifs.w_valid   = ifb.w_valid;
  assign ifs.w_data    = ifb.w_data;
  assign ifs.out_ready = 1'b1;

  conv1d_stream_mac #(.IN_LEN(4), .IN_CH(1), .NUM_FILTERS(2), .KERNEL_SIZE(3), .STRIDE(1),
                      .PADDING(1), .ACTIV_BITS(16), .FRAC_BITS(0), .ACC_BITS(40)) u_base (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .start(start), .relu_en(relu_en),
    .data_in(data_in), .bus(ifb.slave), .busy(busy_b), .weights_loaded(wl_b), .done(done_b));

  conv1d_stream_mac #(.IN_LEN(4), .IN_CH(1), .NUM_FILTERS(2), .KERNEL_SIZE(3), .STRIDE(2),
                      .PADDING(1), .ACTIV_BITS(16), .FRAC_BITS(0), .ACC_BITS(40)) u_s2 (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .start(start), .relu_en(relu_en),
    .data_in(data_in), .bus(ifs.slave), .busy(busy_s), .weights_loaded(wl_s), .done(done_s));

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    data;
    int    pos;
    int    filt;
    int    last;
  } row_t;

  row_t rows [24];
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   cap_data [8];
  int   cap_pos [8];
  int   cap_filt [8];
  int   cap_last [8];
  int   s2_data [$];
  int   s2_pos [$];

  always @(negedge clk) begin
    if (done_b) done_cnt++;
    if (ifs.out_valid) begin
      s2_data.push_back(int'(ifs.out_data));
      s2_pos.push_back(int'(ifs.out_pos));
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic load_weights(input logic signed [15:0] w [8], input bit gaps);
    int guard;
    @(negedge clk) load_start = 1'b1;
    @(negedge clk) load_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        ifb.w_valid = 1'b0;
        repeat ((i % 2) + 1) @(negedge clk);
      end
      ifb.w_valid = 1'b1;
      ifb.w_data  = w[i];
      guard = 0;
      while (!ifb.w_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 20) check("w_ready_timeout", guard, 0);
      @(negedge clk);
    end
    ifb.w_valid = 1'b0;
    check("weights_loaded", int'(wl_b), 1);
  endtask

  task automatic run_frame(input logic [63:0] frame, input logic relu, input int hold);
    int n, cnt, guard, d0, ok;
    int snap_d, snap_p, snap_f;
    data_in       = frame;
    relu_en       = relu;
    ifb.out_ready = (hold == 0);
    s2_data.delete();
    s2_pos.delete();
    d0 = done_cnt;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (!ifb.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("first_latency", n, 4);
    if (hold > 0) begin
      snap_d = int'(ifb.out_data);
      snap_p = int'(ifb.out_pos);
      snap_f = int'(ifb.out_filter);
      ok = 1;
      repeat (hold) begin
        @(negedge clk);
        if (!ifb.out_valid || int'(ifb.out_data) != snap_d ||
            int'(ifb.out_pos) != snap_p || int'(ifb.out_filter) != snap_f) ok = 0;
      end
      check("hold_stable", ok, 1);
      ifb.out_ready = 1'b1;
    end
    cnt = 0;
    guard = 0;
    while (cnt < 8 && guard < 400) begin
      if (ifb.out_valid) begin
        cap_data[cnt] = int'(ifb.out_data);
        cap_pos[cnt]  = int'(ifb.out_pos);
        cap_filt[cnt] = int'(ifb.out_filter);
        cap_last[cnt] = int'(ifb.out_last);
        cnt++;
      end
      @(negedge clk);
      guard++;
    end
    check("result_count", cnt, 8);
    repeat (6) @(negedge clk);
    check("no_extra_valid", int'(ifb.out_valid), 0);
    check("done_pulses", done_cnt - d0, 1);
    check("idle_after", int'(busy_b), 0);
  endtask

  task automatic check_rows(input int base);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_%0d_data", rows[base+i].name, i), cap_data[i], rows[base+i].data);
      check($sformatf("%s_%0d_pos",  rows[base+i].name, i), cap_pos[i],  rows[base+i].pos);
      check($sformatf("%s_%0d_filt", rows[base+i].name, i), cap_filt[i], rows[base+i].filt);
      check($sformatf("%s_%0d_last", rows[base+i].name, i), cap_last[i], rows[base+i].last);
    end
  endtask

  initial begin
    logic signed [15:0] w_a [8];
    logic signed [15:0] w_sat [8];
    int a_exp [8];
    int r_exp [8];
    int s_exp [8];
    int s2_exp [4];
    int s2p_exp [4];
    int ok;
    logic [63:0] frame_a, frame_sat;

    w_a     = '{16'sd0, 16'sd1, 16'sd1, 16'sd1, -16'sd10, 16'sd1, 16'sd0, 16'sd0};
    w_sat   = '{16'sd0, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sd0, -16'sh7FFF, -16'sh7FFF, -16'sh7FFF};
    a_exp   = '{3, -10, 6, -9, 9, -8, 7, -7};
    r_exp   = '{3, 0, 6, 0, 9, 0, 7, 0};
    s_exp   = '{32767, -32768, 32767, -32768, 32767, -32768, 32767, -32768};
    s2_exp  = '{3, -10, 9, -8};
    s2p_exp = '{0, 0, 1, 1};
    frame_a   = {16'd4, 16'd3, 16'd2, 16'd1};
    frame_sat = {4{16'h7FFF}};
    for (int i = 0; i < 8; i++) begin
      rows[i].name    = "frameA";  rows[i].data    = a_exp[i];
      rows[i+8].name  = "relu";    rows[i+8].data  = r_exp[i];
      rows[i+16].name = "sat";     rows[i+16].data = s_exp[i];
      for (int b = 0; b < 24; b += 8) begin
        rows[b+i].pos  = i / 2;
        rows[b+i].filt = i % 2;
        rows[b+i].last = (i == 7) ? 1 : 0;
      end
    end

    rst_n = 1'b0; load_start = 1'b0; start = 1'b0; relu_en = 1'b0; data_in = '0;
    ifb.w_valid = 1'b0; ifb.w_data = '0; ifb.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", int'(ifb.out_valid), 0);
    check("rst_out_data", int'(ifb.out_data), 0);
    check("rst_busy", int'(busy_b), 0);
    check("rst_weights_loaded", int'(wl_b), 0);
    check("rst_done", int'(done_b), 0);
    check("rst_w_ready", int'(ifb.w_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Start without weights must be ignored.
    data_in = frame_a;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    ok = 1;
    repeat (8) begin
      if (busy_b || ifb.out_valid) ok = 0;
      @(negedge clk);
    end
    check("start_no_weights_ignored", ok, 1);

    load_weights(w_a, 1'b0);
    run_frame(frame_a, 1'b0, 5);
    check_rows(0);
    check("s2_count", s2_data.size(), 4);
    for (int i = 0; i < 4 && i < s2_data.size(); i++) begin
      check($sformatf("s2_%0d_data", i), s2_data[i], s2_exp[i]);
      check($sformatf("s2_%0d_pos", i), s2_pos[i], s2p_exp[i]);
    end

    run_frame(frame_a, 1'b1, 0);
    check_rows(8);

    // Asynchronous reset in the middle of a MAC sequence.
    relu_en = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_data", int'(ifb.out_data), 0);
    check("midrst_out_valid", int'(ifb.out_valid), 0);
    check("midrst_busy", int'(busy_b), 0);
    check("midrst_weights_loaded", int'(wl_b), 0);
    check("midrst_out_last", int'(ifb.out_last), 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    load_weights(w_a, 1'b1);
    run_frame(frame_a, 1'b0, 0);
    check_rows(0);

    load_weights(w_sat, 1'b0);
    run_frame(frame_sat, 1'b0, 0);
    check_rows(16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=timeout expected=finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/conv1d_stream_mac.md
Name: conv1d_stream_mac

Overview:
Parametrised, time-multiplexed 1-D convolution engine for the MFCC keyword-spotting front end.
- Filter weights and biases arrive on a valid/ready word stream fed by the PSRAM fetch logic, and are held in local registers.
- One input frame is latched per start; each output is computed with one signed MAC per cycle.
- Supports multiple channels, stride, zero padding, fixed-point rescale, optional ReLU and saturation.
- Results leave as a backpressured stream, position-major, filter-minor.

Parameters:
- IN_LEN, 40, input positions per channel
- IN_CH, 1, input channels
- NUM_FILTERS, 8, output filters
- KERNEL_SIZE, 3, taps per channel
- STRIDE, 1, output step in input positions
- PADDING, 1, zero positions added at each end
- ACTIV_BITS, 16, signed activation, weight and bias width
- FRAC_BITS, 8, fractional bits in the weights (output shift)
- ACC_BITS, 40, signed accumulator width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- load_start  in  1  pulse: begin weight load (accepted in IDLE only)
- w_valid  in  1  weight word valid
- w_ready  out  1  weight word accepted when w_valid&w_ready
- w_data  in  ACTIV_BITS  bias/weight word, signed
- start  in  1  pulse: latch data_in and convolve (accepted in IDLE with weights_loaded=1 only)
- relu_en  in  1  apply ReLU; sampled with start
- data_in  in  IN_LEN*IN_CH*ACTIV_BITS  frame; element (pos,ch) at [(pos*IN_CH+ch)*ACTIV_BITS +: ACTIV_BITS]
- out_valid  out  1  result valid
- out_ready  in  1  consumer ready
- out_data  out  ACTIV_BITS  signed result
- out_pos  out  clog2(OUT_LEN)  output position index (min width 1)
- out_filter  out  clog2(NUM_FILTERS)  filter index (min width 1)
- out_last  out  1  final result of frame
- busy  out  1  state != IDLE
- weights_loaded  out  1  a complete weight set is held
- done  out  1  one-cycle pulse after the last result is accepted

Behaviour:
- OUT_LEN = (IN_LEN + 2*PADDING - KERNEL_SIZE)/STRIDE + 1; TAPS = IN_CH*KERNEL_SIZE.
- Reset values: all outputs 0; weights_loaded=0; state IDLE. Stored weights need no reset.
- Reset mid-operation aborts everything. weights_loaded=0 afterwards, so weights must be reloaded.
- States: IDLE, LOAD, MAC, EMIT, DONE.
- IDLE:
  - load_start takes priority over start; goes to LOAD and clears weights_loaded.
  - start with weights_loaded=1 latches data_in and relu_en and goes to MAC.
  - start with weights_loaded=0 is ignored. Both pulses are ignored outside IDLE.
- LOAD:
  - w_ready=1. Accepts NUM_FILTERS*(1+TAPS) words.
  - Word order: per filter f ascending, bias first, then ch ascending, then k ascending.
  - After the last handshake: weights_loaded=1, go to IDLE.
- MAC:
  - On entry: acc = sign-extended bias <<< FRAC_BITS.
  - Then exactly TAPS cycles, one term per cycle: term(ch,k) = w[f][ch][k]*x[pos*STRIDE+k-PADDING][ch].
  - An out-of-range index contributes 0 (padding).
  - Product is full 2*ACTIV_BITS signed, sign-extended into acc, wrapping at ACC_BITS.
- Result computation:
  - r = acc >>> FRAC_BITS (arithmetic, truncate toward -inf).
  - If relu_en and r<0: r=0.
  - Saturate r to [-2^(ACTIV_BITS-1), 2^(ACTIV_BITS-1)-1].
  - Register r into out_data with out_pos, out_filter and out_last; go to EMIT.
- Latency: out_valid rises TAPS+1 cycles after the start handshake cycle.
  - Each further result follows TAPS+1 cycles after the previous one is accepted.
- EMIT:
  - out_valid=1; out_data, out_pos, out_filter and out_last are held stable while out_ready=0.
  - On out_valid&out_ready: out_valid falls; advance filter, wrapping to 0 and incrementing pos.
  - Go to MAC, or to DONE if out_last.
- DONE: done=1 for one cycle, then IDLE. A new start is accepted the cycle after.
- Weights persist across frames until the next load_start or reset.

Test Plan:
- Base config for all tests: IN_LEN=4, IN_CH=1, NUM_FILTERS=2, K=3, PAD=1, STRIDE=1, FRAC_BITS=0.
- Load f0 bias 0 taps {1,1,1}, f1 bias -10 taps {1,0,0}; frame {1,2,3,4}; relu_en=0 -> f0 outputs 3,6,9,7; f1 outputs -10,-9,-8,-7; out_last only on (pos3,f1); done pulses once; first out_valid 4 cycles after start.
- Same frame with relu_en=1 -> f1 outputs all 0; f0 unchanged.
- STRIDE=2 rebuild, same weights and frame -> OUT_LEN=2; f0 outputs 3 (pos0), 9 (pos1).
- Saturation: bias 0, taps {0x7FFF,0x7FFF,0x7FFF}, frame all 0x7FFF -> 0x7FFF. Negate the taps with relu_en=0 -> 0x8000.
- Backpressure: hold out_ready=0 for 5 cycles on the first result -> out_valid stays 1 and outputs are stable; no result is lost or duplicated.
- Start with weights_loaded=0 -> busy stays 0, no out_valid.
- Reset asserted during MAC -> all outputs 0, weights_loaded=0.
- Load with w_valid gaps -> identical results to the gap-free load.
